mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Data-memory access engine of the multicycle MIPS datapath; it produces the readData word that write-back muxes into the register file.
//  Accepts one load/store per start pulse from control, aligns and byte-enables the access onto a req/ack memory bus, sign/zero-extends
//  load data, and holds the result in an internal MDR until the next load completes. Flags misaligned, illegal and timed-out accesses.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles mem_req may wait for mem_ack before the access aborts with bus_error (>=1)
// PORTS
//  clk            in   1   system clock; all state updates on rising edge
//  reset          in   1   synchronous, active-high reset
//  start          in   1   one-cycle request pulse from control FSM; ignored while busy=1
//  mem_read       in   1   load request (sampled with start)
//  mem_write      in   1   store request (sampled with start)
//  size           in   2   00 byte, 01 half, 10 word, 11 illegal (sampled with start)
//  load_unsigned  in   1   1 = zero-extend (lbu/lhu), 0 = sign-extend (sampled with start)
//  addr           in   32  byte address from ALUResult (sampled with start)
//  store_data     in   32  rt value; low bits used for sb/sh (sampled with start)
//  busy           out  1   1 from cycle after accepted start through the done cycle
//  done           out  1   one-cycle pulse: access finished (ok or error)
//  read_data      out  32  MDR: extended load result; changes only on done of a successful load
//  misaligned     out  1   valid with done: half at addr[0]=1 or word at addr[1:0]!=0
//  illegal        out  1   valid with done: size=11 or mem_read&mem_write both set
//  bus_error      out  1   valid with done: mem_ack not seen within TIMEOUT_CYCLES
//  mem_req        out  1   bus request, registered; held high until ack or timeout
//  mem_we         out  1   1 = store; stable while mem_req=1
//  mem_addr       out  32  {addr[31:2],2'b00}; stable while mem_req=1
//  mem_be         out  4   byte enables; lane i = bits 8i+7:8i (little-endian lanes)
//  mem_wdata      out  32  store data replicated to addressed lane(s)
//  mem_rdata      in   32  read word, valid in the cycle mem_ack=1
//  mem_ack        in   1   access complete; counted only while mem_req=1
// BEHAVIOUR
//  Reset: state IDLE; busy, done, misaligned, illegal, bus_error, mem_req, mem_we = 0; read_data, mem_addr, mem_be, mem_wdata = 0.
//  FSM: IDLE -> CHECK on start & (mem_read|mem_write); start with neither set is ignored (no done).
//   CHECK (1 cycle): illegal or misaligned -> DONE, no bus cycle; else -> REQ with mem_req=1 registered.
//   REQ: mem_ack=1 -> DONE; wait counter reaches TIMEOUT_CYCLES -> DONE with bus_error, mem_req drops.
//   DONE (1 cycle): done=1 with error flags; -> IDLE. Error flags are 0 outside the done cycle.
//  Latency: start at T -> mem_req from T+2; ack at T+1+k (k>=1) -> done at T+2+k. Minimum start-to-done = 3 cycles.
//  Inputs are captured at start; later changes to addr/size/etc. do not affect the access in flight.
//  Byte enables: byte -> 1<<addr[1:0]; half -> 4'b0011 (addr[1]=0) / 4'b1100 (addr[1]=1); word -> 4'b1111.
//  Store data: byte -> {4{sd[7:0]}}; half -> {2{sd[15:0]}}; word -> sd. Loads drive mem_be of the access and mem_we=0.
//  Load extract: lane selected by captured addr[1:0]; bit 7/15 replicated unless load_unsigned=1. Word loads are never extended.
//  read_data updates only on successful load completion; stores and errored accesses leave it unchanged.
//  mem_ack with mem_req=0 is ignored. An ack and timeout in the same cycle count as a successful ack.
//  Reset mid-access: synchronous abort, mem_req=0 next edge, no done pulse; late mem_ack afterward ignored.
//  Wait counter is $clog2(TIMEOUT_CYCLES+1) bits, cleared on entry to REQ, saturates; no wrap.
// STRUCTURE
//  Package mips_mem_pkg: SIZE_BYTE/SIZE_HALF/SIZE_WORD encodings, FSM state encodings (IDLE, CHECK, REQ, DONE).
//  Sub-module mem_lane_align (combinational): byte-enable/store replication and load extract/extend.
//  Top: capture registers, FSM, timeout counter, MDR.
// TESTING
//  1 lw addr=0x100, ack after 2 cycles, rdata=0xDEADBEEF -> mem_addr=0x100, be=1111, done once, read_data=0xDEADBEEF.
//  2 lb addr=0x103, rdata=0x80112233, signed -> be=1000, read_data=0xFFFFFF80; lbu same -> 0x00000080.
//  3 sh addr=0x202, store_data=0x0000ABCD -> mem_we=1, be=1100, wdata=0xABCDABCD, read_data unchanged.
//  4 lw addr=0x101 -> no mem_req ever, done with misaligned=1 at start+2; size=11 -> illegal=1, same timing.
//  5 TIMEOUT_CYCLES=4, no ack -> mem_req high exactly 4 cycles, then done with bus_error=1, read_data unchanged.
//  6 reset asserted while mem_req=1, then ack -> outputs at reset values, no done; new start afterwards completes normally.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the data-memory access engine.
//   SIZE_*  : access-size encodings of the size port
//   state_e : access FSM states
package mips_mem_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StReq,
        StDone
    } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering for the data-memory access engine.
//   size_i, addr_lo_i, load_unsigned_i : captured access attributes
//   store_data_i : rt value; be_o / wdata_o : byte enables and replicated store word
//   rdata_i      : raw bus read word; rdata_ext_o : selected lane, sign/zero-extended
module mem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        load_unsigned_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_ext_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        byte_sign;
    logic        half_sign;

    always_comb begin
        byte_v    = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_v    = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        byte_sign = byte_v[7] & ~load_unsigned_i;
        half_sign = half_v[15] & ~load_unsigned_i;
    end

    always_comb begin
        be_o        = 4'b0000;
        wdata_o     = 32'h0;
        rdata_ext_o = 32'h0;
        unique case (size_i)
            SIZE_BYTE: begin
                be_o        = 4'b0001 << addr_lo_i;
                wdata_o     = {4{store_data_i[7:0]}};
                rdata_ext_o = {{24{byte_sign}}, byte_v};
            end
            SIZE_HALF: begin
                be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o     = {2{store_data_i[15:0]}};
                rdata_ext_o = {{16{half_sign}}, half_v};
            end
            SIZE_WORD: begin
                be_o        = 4'b1111;
                wdata_o     = store_data_i;
                rdata_ext_o = rdata_i;
            end
            default: ;  // illegal size never reaches the bus
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access engine: one load/store per start pulse, driven onto a req/ack bus.
//   Control : clk_i, reset_i (sync, active-high), start_i, mem_read_i, mem_write_i, size_i,
//             load_unsigned_i, addr_i, store_data_i
//   Status  : busy_o, done_o, misaligned_o, illegal_o, bus_error_o, read_data_o (MDR)
//   Bus     : mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o, mem_rdata_i, mem_ack_i
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [1:0]  size_i,
    input  logic        load_unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] read_data_o,
    output logic        misaligned_o,
    output logic        illegal_o,
    output logic        bus_error_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    state_e          state_q, state_d;
    logic            rd_q, rd_d;
    logic            wr_q, wr_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     sd_q, sd_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [3:0]      mem_be_q, mem_be_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic [31:0]     read_data_q, read_data_d;
    logic            misaligned_q, misaligned_d;
    logic            illegal_q, illegal_d;
    logic            bus_error_q, bus_error_d;

    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        chk_illegal;
    logic        chk_misaligned;
    logic        timeout_hit;

    mem_lane_align u_align (
        .size_i          (size_q),
        .addr_lo_i       (addr_q[1:0]),
        .load_unsigned_i (uns_q),
        .store_data_i    (sd_q),
        .rdata_i         (mem_rdata_i),
        .be_o            (al_be),
        .wdata_o         (al_wdata),
        .rdata_ext_o     (al_rdata)
    );

    always_comb begin
        chk_illegal    = (size_q == SIZE_ILLEGAL) | (rd_q & wr_q);
        chk_misaligned = ((size_q == SIZE_HALF) & addr_q[0]) |
                         ((size_q == SIZE_WORD) & (addr_q[1:0] != 2'b00));
        // cnt_q counts REQ cycles already spent without ack; this cycle is cnt_q + 1.
        timeout_hit    = (32'(cnt_q) + 32'd1) >= TIMEOUT_CYCLES;
    end

    always_comb begin
        state_d      = state_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        sd_d         = sd_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        read_data_d  = read_data_q;
        // error flags are single-cycle: only set on the edge into StDone
        misaligned_d = 1'b0;
        illegal_d    = 1'b0;
        bus_error_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i && (mem_read_i || mem_write_i)) begin
                    rd_d    = mem_read_i;
                    wr_d    = mem_write_i;
                    size_d  = size_i;
                    uns_d   = load_unsigned_i;
                    addr_d  = addr_i;
                    sd_d    = store_data_i;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (chk_illegal || chk_misaligned) begin
                    illegal_d    = chk_illegal;
                    misaligned_d = chk_misaligned;
                    state_d      = StDone;
                end else begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = wr_q;
                    mem_addr_d  = {addr_q[31:2], 2'b00};
                    mem_be_d    = al_be;
                    mem_wdata_d = al_wdata;
                    cnt_d       = '0;
                    state_d     = StReq;
                end
            end
            StReq: begin
                // ack wins over a timeout landing in the same cycle
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    if (rd_q) begin
                        read_data_d = al_rdata;
                    end
                    state_d = StDone;
                end else if (timeout_hit) begin
                    mem_req_d   = 1'b0;
                    bus_error_d = 1'b1;
                    state_d     = StDone;
                end else if (cnt_q != {CntW{1'b1}}) begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            size_q       <= SIZE_BYTE;
            uns_q        <= 1'b0;
            addr_q       <= 32'h0;
            sd_q         <= 32'h0;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_be_q     <= 4'h0;
            mem_wdata_q  <= 32'h0;
            read_data_q  <= 32'h0;
            misaligned_q <= 1'b0;
            illegal_q    <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            sd_q         <= sd_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            read_data_q  <= read_data_d;
            misaligned_q <= misaligned_d;
            illegal_q    <= illegal_d;
            bus_error_q  <= bus_error_d;
        end
    end

    assign busy_o       = (state_q != StIdle);
    assign done_o       = (state_q == StDone);
    assign read_data_o  = read_data_q;
    assign misaligned_o = misaligned_q;
    assign illegal_o    = illegal_q;
    assign bus_error_o  = bus_error_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_be_o     = mem_be_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule
